// File: rtl/mmio_ram_pkg.sv
// Shared constants for mmio_ram: MMIO address map and the BCD to 7-segment table.
package mmio_ram_pkg;

    localparam int unsigned ADDR_DISP      = 0;
    localparam int unsigned ADDR_BTN_LEVEL = 1;
    localparam int unsigned ADDR_BTN_PRESS = 2;
    localparam int unsigned ADDR_IRQ_MASK  = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}, a = bit 6; index = nibble value, 10..15 blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/mmio_ram_if.sv
// CPU-side data bus of mmio_ram: address, write strobe, write data and combinational read data.
interface mmio_ram_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] result;

    modport master (output addr, output write, output value, input result);
    modport slave  (input addr, input write, input value, output result);
endinterface

// File: rtl/btn_debounce.sv
// Single-bit button debouncer: 2-flop synchroniser followed by a stability counter.
// rise is high in the cycle before level goes 0->1, so a flag can capture it on the same edge.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count while the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and accepted level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = ~level_q & level_d;
endmodule

// File: rtl/mmio_ram.sv
// Data RAM with an MMIO window: display register, debounced buttons, sticky press flags.
// Optional feature macro MMIO_PRESS_IRQ_EN adds an irq mask register at address 3 and an irq
// output; RAM then starts at address 4 instead of 3.
module mmio_ram
    import mmio_ram_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned NUM_BTN    = 4,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned SCAN_DIV   = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    mmio_ram_if.slave             bus,
    input  logic [NUM_BTN-1:0]    btn_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_en
`ifdef MMIO_PRESS_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MEM_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MMIO_PRESS_IRQ_EN
    localparam int unsigned RAM_BASE = ADDR_IRQ_MASK + 1;
`else
    localparam int unsigned RAM_BASE = ADDR_IRQ_MASK;
`endif

    logic [31:0] addr_ext;
    logic        sel_disp, sel_level, sel_press, sel_ram;

    logic [DATA_W-1:0]     disp_q;
    logic [NUM_BTN-1:0]    flags_q, flags_d;
    logic [NUM_BTN-1:0]    btn_level, btn_rise;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [DATA_W-1:0]     mem [DEPTH];

    // Widen the address so range checks work for any ADDR_W/DEPTH pairing.
    assign addr_ext  = 32'(bus.addr);
    assign sel_disp  = (addr_ext == ADDR_DISP);
    assign sel_level = (addr_ext == ADDR_BTN_LEVEL);
    assign sel_press = (addr_ext == ADDR_BTN_PRESS);
    assign sel_ram   = (addr_ext >= RAM_BASE) && (addr_ext < DEPTH);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (btn_in[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i])
        );
    end

`ifdef MMIO_PRESS_IRQ_EN
    logic               sel_mask;
    logic [NUM_BTN-1:0] mask_q;
    logic               irq_q;

    assign sel_mask = (addr_ext == ADDR_IRQ_MASK);

    // Mask register and registered interrupt level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (bus.write && sel_mask) begin
                mask_q <= bus.value[NUM_BTN-1:0];
            end
            irq_q <= |(flags_q & mask_q);
        end
    end

    assign irq = irq_q;
`endif

    // Press flags (W1C, set wins) and the display scan sequence.
    always_comb begin
        flags_d = flags_q;
        if (bus.write && sel_press) begin
            flags_d = flags_q & ~bus.value[NUM_BTN-1:0];
        end
        flags_d = flags_d | btn_rise;

        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        seg_d = SEG_TABLE[disp_q[{idx_d, 2'b00} +: 4]];
        en_d  = ~(NUM_DIGITS'(1) << idx_d);
    end

    // MMIO registers and display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q  <= '0;
            flags_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_TABLE[0];
            en_q    <= ~NUM_DIGITS'(1);
        end else begin
            if (bus.write && sel_disp) begin
                disp_q <= bus.value;
            end
            flags_q <= flags_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
        end
    end

    // RAM storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && bus.write && sel_ram) begin
            mem[bus.addr[MEM_W-1:0]] <= bus.value;
        end
    end

    // Combinational read mux.
    always_comb begin
        bus.result = '0;
        if (sel_disp) begin
            bus.result = disp_q;
        end else if (sel_level) begin
            bus.result[NUM_BTN-1:0] = btn_level;
        end else if (sel_press) begin
            bus.result[NUM_BTN-1:0] = flags_q;
`ifdef MMIO_PRESS_IRQ_EN
        end else if (sel_mask) begin
            bus.result[NUM_BTN-1:0] = mask_q;
`endif
        end else if (sel_ram) begin
            bus.result = mem[bus.addr[MEM_W-1:0]];
        end
    end

    assign seg      = seg_q;
    assign digit_en = en_q;
endmodule

// File: tb/tb_mmio_ram.sv
// Self-checking bench for mmio_ram: table-driven bus vectors plus directed button,
// display-scan and reset sequences. Irq checks are built when MMIO_PRESS_IRQ_EN is defined.
module tb_mmio_ram;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_in = '0;
    logic [6:0] seg;
    logic [3:0] digit_en;
`ifdef MMIO_PRESS_IRQ_EN
    logic       irq;
`endif

    int checks   = 0;
    int failures = 0;

    mmio_ram_if #(.DATA_W(32), .ADDR_W(11)) bus ();

    mmio_ram #(
        .DATA_W    (32),
        .ADDR_W    (11),
        .DEPTH     (1024),
        .NUM_BTN   (4),
        .NUM_DIGITS(4),
        .DB_CYCLES (16),
        .SCAN_DIV  (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .btn_in  (btn_in),
        .seg     (seg),
        .digit_en(digit_en)
`ifdef MMIO_PRESS_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] value;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] d);
        bus.addr  = a;
        bus.write = 1'b0;
        #1;
        d = bus.result;
    endtask

    task automatic check_rd(input string nm, input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(nm, d, exp);
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] v);
        bus.addr  = a;
        bus.value = v;
        bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic wait_en(input logic [3:0] t, input int budget, input string nm);
        int n = 0;
        while (digit_en !== t && n < budget) begin
            tick();
            n++;
        end
        check(nm, 32'(digit_en), 32'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  en_exp  [4];
        logic [6:0]  seg_exp [4];

        bus.addr  = '0;
        bus.write = 1'b0;
        bus.value = '0;

        // Address, write, expected read-back at the same address.
        vecs[0]  = '{1'b1, 11'd100,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 11'd1,    32'hFFFFFFFF, 32'h0};
        vecs[2]  = '{1'b0, 11'd1024, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 11'd1024, 32'h12345678, 32'h0};
        vecs[4]  = '{1'b1, 11'd1023, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{1'b1, 11'd2047, 32'hFFFFFFFF, 32'h0};
        vecs[6]  = '{1'b0, 11'd1023, 32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 11'd1124, 32'h77777777, 32'h0};
        vecs[8]  = '{1'b0, 11'd100,  32'h0,        32'hDEADBEEF};
`ifdef MMIO_PRESS_IRQ_EN
        vecs[9]  = '{1'b1, 11'd3,    32'h11111111, 32'h00000001};
`else
        vecs[9]  = '{1'b1, 11'd3,    32'h11111111, 32'h11111111};
`endif
        vecs[10] = '{1'b1, 11'd0,    32'hCAFE0000, 32'hCAFE0000};
        vecs[11] = '{1'b1, 11'd2,    32'h0000000F, 32'h0};
        vecs[12] = '{1'b1, 11'd500,  32'h00000011, 32'h00000011};

        en_exp[0]  = 4'b1110;  seg_exp[0] = 7'b1001111;  // "1"
        en_exp[1]  = 4'b1101;  seg_exp[1] = 7'b0001111;  // "7"
        en_exp[2]  = 4'b1011;  seg_exp[2] = 7'b1111111;  // blank (0xA)
        en_exp[3]  = 4'b0111;  seg_exp[3] = 7'b0000110;  // "3"

        // Reset state.
        repeat (3) tick();
        check("rst_seg", 32'(seg), 32'h01);
        check("rst_en", 32'(digit_en), 32'hE);
        check_rd("rst_disp", 11'd0, 32'h0);
        check_rd("rst_level", 11'd1, 32'h0);
        check_rd("rst_press", 11'd2, 32'h0);
`ifdef MMIO_PRESS_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        reset = 1'b0;
        tick();
        check("post_rst_en", 32'(digit_en), 32'hE);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].value);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // 10-cycle glitch on button 0 is rejected.
        btn_in[0] = 1'b1;
        repeat (10) tick();
        btn_in[0] = 1'b0;
        repeat (25) tick();
        check_rd("glitch_level", 11'd1, 32'h0);
        check_rd("glitch_press", 11'd2, 32'h0);

        // Button 2: level changes exactly DB_CYCLES+2 edges after the raw edge.
        btn_in[2] = 1'b1;
        repeat (17) tick();
        check_rd("b2_level_early", 11'd1, 32'h0);
        tick();
        check_rd("b2_level", 11'd1, 32'h4);
        check_rd("b2_press", 11'd2, 32'h4);

        btn_in[0] = 1'b1;
        repeat (18) tick();
        check_rd("b0_level", 11'd1, 32'h5);
        check_rd("b0_press", 11'd2, 32'h5);
        wr(11'd2, 32'h1);
        check_rd("w1c_bit0", 11'd2, 32'h4);
        check_rd("w1c_level_kept", 11'd1, 32'h5);
        wr(11'd2, 32'h0);
        check_rd("w1c_zero", 11'd2, 32'h4);
        wr(11'd2, 32'h4);
        check_rd("w1c_bit2", 11'd2, 32'h0);

        // Set and clear of bit 2 on the same edge: set wins.
        btn_in[2] = 1'b0;
        repeat (20) tick();
        check_rd("b2_release", 11'd1, 32'h1);
        btn_in[2] = 1'b1;
        repeat (17) tick();
        wr(11'd2, 32'h4);
        check_rd("set_wins_press", 11'd2, 32'h4);
        check_rd("set_wins_level", 11'd1, 32'h5);

        // Display scan: 4 cycles per digit, seg and digit_en aligned.
        wr(11'd0, 32'h00003A71);
        wait_en(4'b0111, 20, "scan_sync3");
        wait_en(4'b1110, 6, "scan_sync0");
        for (int dg = 0; dg < 4; dg++) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("scan_en_d%0d_c%0d", dg, k), 32'(digit_en), 32'(en_exp[dg]));
                check($sformatf("scan_seg_d%0d_c%0d", dg, k), 32'(seg), 32'(seg_exp[dg]));
                tick();
            end
        end

        // Reset mid-scan at digit 2 with a debounce count pending on button 1.
        wait_en(4'b1011, 20, "scan_at2");
        btn_in[1] = 1'b1;
        repeat (3) tick();
        check("pre_rst_en", 32'(digit_en), 32'hB);
        reset  = 1'b1;
        btn_in = '0;
        #1;
        check("mid_rst_en", 32'(digit_en), 32'hE);
        check("mid_rst_seg", 32'(seg), 32'h01);
        check_rd("mid_rst_level", 11'd1, 32'h0);
        check_rd("mid_rst_press", 11'd2, 32'h0);
`ifdef MMIO_PRESS_IRQ_EN
        check("mid_rst_irq", 32'(irq), 32'h0);
`endif
        wr(11'd0, 32'h5);
        wr(11'd500, 32'h22);
        reset = 1'b0;
        check_rd("rst_write_disp_lost", 11'd0, 32'h0);
        check_rd("rst_write_ram_lost", 11'd500, 32'h11);
        check_rd("ram_kept", 11'd100, 32'hDEADBEEF);
        tick();
        check("after_rst_en", 32'(digit_en), 32'hE);
        check("after_rst_seg", 32'(seg), 32'h01);
        repeat (25) tick();
        check_rd("pending_dropped", 11'd1, 32'h0);

`ifdef MMIO_PRESS_IRQ_EN
        wr(11'd3, 32'h2);
        check_rd("mask_rd", 11'd3, 32'h2);
        btn_in[0] = 1'b1;
        repeat (18) tick();
        check_rd("irq_b0_press", 11'd2, 32'h1);
        check("irq_b0_a", 32'(irq), 32'h0);
        tick();
        check("irq_b0_b", 32'(irq), 32'h0);
        wr(11'd2, 32'h1);
        btn_in[1] = 1'b1;
        repeat (18) tick();
        check_rd("irq_b1_press", 11'd2, 32'h2);
        check("irq_b1_same", 32'(irq), 32'h0);
        tick();
        check("irq_b1_rise", 32'(irq), 32'h1);
        wr(11'd2, 32'h2);
        check("irq_clr_same", 32'(irq), 32'h1);
        tick();
        check("irq_clr_fall", 32'(irq), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
